// File: rtl/div_arb.sv
// div_arb: round-robin scheduler sharing one 64-bit SRT divider among NREQ requesters.
// Latency: accept -> div_vld_o next cycle -> rsp_vld_o one cycle after div_rdy_i is seen rising.
// Backpressure: rsp_rdy_i low holds the response (and blocks all grants) indefinitely.
//
// Ports:
//   clk, rstn                 clock, async active-low reset (shared with the divider)
//   req_vld_i/req_rdy_o       per-requester handshake; req_rdy_o is one-hot or zero
//   req_op1_i/req_op2_i       packed dividends/divisors, requester k at [64k+63:64k]
//   div_vld_o/div_op*_o       issue side towards the divider
//   div_rdy_i/div_quo_i/rem_i divider ready and results
//   rsp_vld_o/rsp_rdy_i       tagged response channel (rsp_id_o, rsp_quo_o, rsp_rem_o, rsp_dz_o)
// Optional feature: define DIV_ARB_DZ_BYPASS_EN to answer divide-by-zero without using the divider.
module div_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_vld_i,
  output logic [NREQ-1:0]      req_rdy_o,
  input  logic [NREQ*64-1:0]   req_op1_i,
  input  logic [NREQ*64-1:0]   req_op2_i,
  output logic                 div_vld_o,
  output logic [63:0]          div_op1_o,
  output logic [63:0]          div_op2_o,
  input  logic                 div_rdy_i,
  input  logic [63:0]          div_quo_i,
  input  logic [63:0]          div_rem_i,
  output logic                 rsp_vld_o,
  input  logic                 rsp_rdy_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [63:0]          rsp_quo_o,
  output logic [63:0]          rsp_rem_o,
  output logic                 rsp_dz_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_e;

  typedef struct packed {
    logic [63:0] quo;
    logic [63:0] rem;
  } rsp_t;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] tag_q, tag_d;
  logic [63:0]    op1_q, op1_d;
  logic [63:0]    op2_q, op2_d;
  logic           seen_low_q, seen_low_d;
  rsp_t           rsp_q, rsp_d;

  // Grant search
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic [63:0]    gnt_op1, gnt_op2;
  logic           gnt_dz;
  logic           gnt_fire;

  // First valid requester at or above rr_ptr, wrapping; one spare bit absorbs the wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!gnt_found && req_vld_i[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign gnt_op1 = req_op1_i[64*gnt_idx +: 64];
  assign gnt_op2 = req_op2_i[64*gnt_idx +: 64];

`ifdef DIV_ARB_DZ_BYPASS_EN
  logic dz_q, dz_d;
  assign gnt_dz = (gnt_op2 == 64'd0);
`else
  assign gnt_dz = 1'b0;
`endif

  // A bypassed zero-divisor request never touches the divider, so it need not wait for it.
  assign gnt_fire  = (state_q == S_IDLE) && gnt_found && (div_rdy_i || gnt_dz);
  assign req_rdy_o = gnt_fire ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tag_d      = tag_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    seen_low_d = seen_low_q;
    rsp_d      = rsp_q;
`ifdef DIV_ARB_DZ_BYPASS_EN
    dz_d       = dz_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gnt_fire) begin
          tag_d    = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
`ifdef DIV_ARB_DZ_BYPASS_EN
          if (gnt_dz) begin
            // Operand registers are left alone so div_op*_o keep the last issued values.
            rsp_d.quo = '1;
            rsp_d.rem = gnt_op1;
            dz_d      = 1'b1;
            state_d   = S_RESP;
          end else begin
            op1_d   = gnt_op1;
            op2_d   = gnt_op2;
            state_d = S_ISSUE;
          end
`else
          op1_d   = gnt_op1;
          op2_d   = gnt_op2;
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        seen_low_d = 1'b0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Ready still high right after issue is the divider not having reacted yet;
        // completion is a low-then-high on div_rdy_i.
        if (!div_rdy_i) begin
          seen_low_d = 1'b1;
        end
        if (seen_low_q && div_rdy_i) begin
          rsp_d.quo = div_quo_i;
          rsp_d.rem = div_rem_i;
`ifdef DIV_ARB_DZ_BYPASS_EN
          dz_d      = 1'b0;
`endif
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_rdy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      tag_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      seen_low_q <= 1'b0;
      rsp_q      <= '0;
`ifdef DIV_ARB_DZ_BYPASS_EN
      dz_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tag_q      <= tag_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      seen_low_q <= seen_low_d;
      rsp_q      <= rsp_d;
`ifdef DIV_ARB_DZ_BYPASS_EN
      dz_q       <= dz_d;
`endif
    end
  end

  assign div_vld_o = (state_q == S_ISSUE);
  assign div_op1_o = op1_q;
  assign div_op2_o = op2_q;
  assign rsp_vld_o = (state_q == S_RESP);
  assign rsp_id_o  = tag_q;
  assign rsp_quo_o = rsp_q.quo;
  assign rsp_rem_o = rsp_q.rem;
`ifdef DIV_ARB_DZ_BYPASS_EN
  assign rsp_dz_o  = dz_q;
`else
  assign rsp_dz_o  = 1'b0;
`endif

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb with a behavioural fixed-latency divider.
module tb_div_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DLAT = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_vld, req_rdy;
  logic [NREQ*64-1:0] req_op1, req_op2;
  logic               div_vld, div_rdy;
  logic [63:0]        div_op1, div_op2, div_quo, div_rem;
  logic               rsp_vld, rsp_rdy, rsp_dz;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_quo, rsp_rem;

  int passed = 0;
  int total  = 0;

  div_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy),
    .req_op1_i(req_op1), .req_op2_i(req_op2),
    .div_vld_o(div_vld), .div_op1_o(div_op1), .div_op2_o(div_op2),
    .div_rdy_i(div_rdy), .div_quo_i(div_quo), .div_rem_i(div_rem),
    .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_quo_o(rsp_quo), .rsp_rem_o(rsp_rem), .rsp_dz_o(rsp_dz)
  );

  // Divider model: busy for DLAT cycles after accepting, signed truncating division,
  // divide-by-zero returns all ones / dividend. div_stall forces ready low.
  int   dcnt;
  logic div_stall;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt    <= 0;
      div_quo <= '0;
      div_rem <= '0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end else if (div_vld && div_rdy) begin
      dcnt <= DLAT;
      if (div_op2 == 64'd0) begin
        div_quo <= '1;
        div_rem <= div_op1;
      end else begin
        div_quo <= $signed(div_op1) / $signed(div_op2);
        div_rem <= $signed(div_op1) % $signed(div_op2);
      end
    end
  end
  assign div_rdy = (dcnt == 0) && !div_stall;

  // Event counters read as before/after deltas.
  int dv_cnt = 0;
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (div_vld) dv_cnt <= dv_cnt + 1;
    if (|(req_vld & req_rdy)) acc_cnt <= acc_cnt + 1;
  end

  task automatic set_req(input int k, input logic [63:0] a, input logic [63:0] b);
    req_vld[k]          = 1'b1;
    req_op1[64*k +: 64] = a;
    req_op2[64*k +: 64] = b;
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      #1;
      if (rsp_vld) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (req_rdy !== 4'b0 || div_vld !== 1'b0 || div_op1 !== 64'd0 || div_op2 !== 64'd0 ||
        rsp_vld !== 1'b0 || rsp_id !== 2'd0 || rsp_quo !== 64'd0 || rsp_rem !== 64'd0 || rsp_dz !== 1'b0)
      $display("FAIL reset_values: rdy=%b dvld=%b op1=%h op2=%h rvld=%b id=%0d quo=%h rem=%h dz=%b, required all zero",
               req_rdy, div_vld, div_op1, div_op2, rsp_vld, rsp_id, rsp_quo, rsp_rem, rsp_dz);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fairness;
    bit ok; int cyc;
    logic [3:0] exp_rdy;
    for (int k = 0; k < NREQ; k++) set_req(k, 64'((k + 2) * 10 + k), 64'd10);
    #1;
    total++;
    if (req_rdy !== 4'b0001) $display("FAIL fair_first_grant: req_rdy=%b required 0001", req_rdy);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      wait_rsp(40, ok, cyc);
      total++;
      if (!ok || rsp_id !== 2'(i % 4) || rsp_quo !== 64'((i % 4) + 2) || rsp_rem !== 64'(i % 4))
        $display("FAIL fair_rsp%0d: ok=%0d id=%0d quo=%0d rem=%0d, required id=%0d quo=%0d rem=%0d",
                 i, ok, rsp_id, rsp_quo, rsp_rem, i % 4, (i % 4) + 2, i % 4);
      else passed++;
      total++;
      if (req_rdy !== 4'b0) $display("FAIL fair_no_grant_in_resp%0d: req_rdy=%b required 0000", i, req_rdy);
      else passed++;
      if (i == 7) begin
        req_vld = '0;
      end else begin
        @(negedge clk);
        #1;
        exp_rdy = 4'b0001 << ((i + 1) % 4);
        total++;
        if (req_rdy !== exp_rdy) $display("FAIL fair_next_grant%0d: req_rdy=%b required %b", i, req_rdy, exp_rdy);
        else passed++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok; int cyc; int dv0, acc0;
    dv0 = dv_cnt; acc0 = acc_cnt;
    set_req(1, 64'd100, 64'd7);
    #1;
    total++;
    if (req_rdy !== 4'b0010) $display("FAIL single_grant: req_rdy=%b required 0010", req_rdy);
    else passed++;
    @(negedge clk);
    req_vld = '0;
    #1;
    total++;
    if (div_vld !== 1'b1 || div_op1 !== 64'd100 || div_op2 !== 64'd7 || req_rdy !== 4'b0)
      $display("FAIL single_issue: dvld=%b op1=%0d op2=%0d rdy=%b required 1/100/7/0000", div_vld, div_op1, div_op2, req_rdy);
    else passed++;
    wait_rsp(40, ok, cyc);
    total++;
    if (!ok || cyc !== DLAT + 2) $display("FAIL single_latency: ok=%0d cycles=%0d required %0d", ok, cyc, DLAT + 2);
    else passed++;
    total++;
    if (rsp_id !== 2'd1 || rsp_quo !== 64'd14 || rsp_rem !== 64'd2 || rsp_dz !== 1'b0)
      $display("FAIL single_rsp: id=%0d quo=%0d rem=%0d dz=%b required 1/14/2/0", rsp_id, rsp_quo, rsp_rem, rsp_dz);
    else passed++;
    total++;
    if (dv_cnt - dv0 !== 1 || acc_cnt - acc0 !== 1)
      $display("FAIL single_pulses: div_vld=%0d accepts=%0d required 1/1", dv_cnt - dv0, acc_cnt - acc0);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (rsp_vld !== 1'b0) $display("FAIL single_rsp_drop: rsp_vld=%b required 0", rsp_vld);
    else passed++;
  endtask

  task automatic test_signed;
    bit ok; int cyc;
    set_req(0, -64'sd100, 64'd7);
    @(negedge clk);
    req_vld = '0;
    wait_rsp(40, ok, cyc);
    total++;
    if (!ok || rsp_id !== 2'd0 || rsp_quo !== 64'hFFFF_FFFF_FFFF_FFF2 || rsp_rem !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL signed_rsp: ok=%0d id=%0d quo=%h rem=%h required 0/FFFFFFFFFFFFFFF2/FFFFFFFFFFFFFFFE",
               ok, rsp_id, rsp_quo, rsp_rem);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok, bad; int cyc;
    rsp_rdy = 1'b0;
    set_req(2, 64'd50, 64'd5);
    set_req(3, 64'd21, 64'd4);
    #1;
    total++;
    if (req_rdy !== 4'b0100) $display("FAIL bp_grant: req_rdy=%b required 0100", req_rdy);
    else passed++;
    @(negedge clk);
    req_vld[2] = 1'b0;
    wait_rsp(40, ok, cyc);
    bad = !ok;
    for (int i = 0; i < 20; i++) begin
      if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_quo !== 64'd10 || rsp_rem !== 64'd0 ||
          req_rdy !== 4'b0 || div_vld !== 1'b0) bad = 1'b1;
      @(negedge clk);
      #1;
    end
    total++;
    if (bad) $display("FAIL bp_hold: vld=%b id=%0d quo=%0d rem=%0d rdy=%b dvld=%b required 1/2/10/0/0000/0",
                      rsp_vld, rsp_id, rsp_quo, rsp_rem, req_rdy, div_vld);
    else passed++;
    rsp_rdy = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (rsp_vld !== 1'b0 || req_rdy !== 4'b1000)
      $display("FAIL bp_release: rsp_vld=%b req_rdy=%b required 0/1000", rsp_vld, req_rdy);
    else passed++;
    @(negedge clk);
    req_vld = '0;
    wait_rsp(40, ok, cyc);
    total++;
    if (!ok || rsp_id !== 2'd3 || rsp_quo !== 64'd5 || rsp_rem !== 64'd1)
      $display("FAIL bp_next_rsp: ok=%0d id=%0d quo=%0d rem=%0d required 3/5/1", ok, rsp_id, rsp_quo, rsp_rem);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    bit ok; int cyc; int dv0;
    dv0 = dv_cnt;
`ifdef DIV_ARB_DZ_BYPASS_EN
    div_stall = 1'b1;
    set_req(1, 64'd55, 64'd0);
    #1;
    total++;
    if (req_rdy !== 4'b0010) $display("FAIL dz_grant_no_div_rdy: req_rdy=%b required 0010", req_rdy);
    else passed++;
    @(negedge clk);
    req_vld = '0;
    #1;
    ok = rsp_vld;
    div_stall = 1'b0;
`else
    set_req(1, 64'd55, 64'd0);
    @(negedge clk);
    req_vld = '0;
    wait_rsp(40, ok, cyc);
`endif
    total++;
    if (!ok || rsp_id !== 2'd1 || rsp_quo !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_rem !== 64'd55)
      $display("FAIL dz_rsp: ok=%0d id=%0d quo=%h rem=%0d required 1/FFFFFFFFFFFFFFFF/55", ok, rsp_id, rsp_quo, rsp_rem);
    else passed++;
`ifdef DIV_ARB_DZ_BYPASS_EN
    total++;
    if (rsp_dz !== 1'b1 || dv_cnt - dv0 !== 0)
      $display("FAIL dz_bypass: dz=%b div_vld pulses=%0d required 1/0", rsp_dz, dv_cnt - dv0);
    else passed++;
`else
    total++;
    if (rsp_dz !== 1'b0 || dv_cnt - dv0 !== 1)
      $display("FAIL dz_through_divider: dz=%b div_vld pulses=%0d required 0/1", rsp_dz, dv_cnt - dv0);
    else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok, bad; int cyc;
    set_req(1, 64'd77, 64'd7);
    @(negedge clk);
    req_vld = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if (req_rdy !== 4'b0 || div_vld !== 1'b0 || div_op1 !== 64'd0 || div_op2 !== 64'd0 ||
        rsp_vld !== 1'b0 || rsp_id !== 2'd0 || rsp_quo !== 64'd0 || rsp_rem !== 64'd0 || rsp_dz !== 1'b0)
      $display("FAIL midreset_values: rdy=%b dvld=%b op1=%0d op2=%0d rvld=%b id=%0d quo=%0d rem=%0d dz=%b required all zero",
               req_rdy, div_vld, div_op1, div_op2, rsp_vld, rsp_id, rsp_quo, rsp_rem, rsp_dz);
    else passed++;
    @(negedge clk);
    div_stall = 1'b1;
    set_req(0, 64'd9, 64'd3);
    set_req(2, 64'd8, 64'd2);
    rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (req_rdy !== 4'b0 || rsp_vld !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL midreset_wait_div: req_rdy=%b rsp_vld=%b required 0000/0", req_rdy, rsp_vld);
    else passed++;
    div_stall = 1'b0;
    #1;
    total++;
    if (req_rdy !== 4'b0001) $display("FAIL midreset_ptr: req_rdy=%b required 0001", req_rdy);
    else passed++;
    @(negedge clk);
    req_vld = '0;
    wait_rsp(40, ok, cyc);
    total++;
    if (!ok || rsp_id !== 2'd0 || rsp_quo !== 64'd3 || rsp_rem !== 64'd0)
      $display("FAIL midreset_fresh: ok=%0d id=%0d quo=%0d rem=%0d required 0/3/0", ok, rsp_id, rsp_quo, rsp_rem);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    rstn      = 1'b0;
    req_vld   = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_rdy   = 1'b1;
    div_stall = 1'b0;
    test_reset;
    test_fairness;
    test_single;
    test_signed;
    test_backpressure;
    test_div_zero;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
